// File: rtl/ex_control_issue.sv
// Execute-stage control issue: decodes an opcode into a one-hot ALU control word and presents it
// to EX, holding multi-cycle MUL/DIV/MOD words for their full latency before marking them valid.
module ex_control_issue #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_opcode,
  input  logic [3:0]  id_rd,
  output logic        id_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [21:9] ALU_Signals,
  output logic [3:0]  ex_rd,
  output logic        illegal_op
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  typedef enum logic [1:0] {StIdle, StHold, StIssue} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [12:0]       word_q, word_d;
  logic              ex_valid_q, ex_valid_d;
  logic [3:0]        ex_rd_q, ex_rd_d;
  logic              illegal_q, illegal_d;

  logic [12:0]       dec_word;
  logic              dec_illegal;
  logic              dec_multi;
  logic [CntW-1:0]   dec_cnt;
  logic              accept;

  // Opcode decode; word bit 0 corresponds to ALU_Signals[9].
  always_comb begin
    dec_word    = '0;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    dec_cnt     = '0;
    case (id_opcode)
      5'b00000, 5'b01110, 5'b01111: dec_word = 13'h0001;
      5'b00001: dec_word = 13'h0002;
      5'b00010: begin
        dec_word = 13'h0008;
        if (MUL_LAT > 1) begin
          dec_multi = 1'b1;
          dec_cnt   = CntW'(MUL_LAT - 1);
        end
      end
      5'b00011, 5'b00100: begin
        dec_word = (id_opcode == 5'b00011) ? 13'h0010 : 13'h0020;
        if (DIV_LAT > 1) begin
          dec_multi = 1'b1;
          dec_cnt   = CntW'(DIV_LAT - 1);
        end
      end
      5'b00101: dec_word = 13'h0004;
      5'b00110: dec_word = 13'h0400;
      5'b00111: dec_word = 13'h0200;
      5'b01000: dec_word = 13'h0800;
      5'b01001: dec_word = 13'h1000;
      5'b01010: dec_word = 13'h0040;
      5'b01011: dec_word = 13'h0080;
      5'b01100: dec_word = 13'h0100;
      5'b01101, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100: dec_word = '0;
      default:  dec_illegal = 1'b1;
    endcase
  end

  assign id_ready = !reset && !flush &&
                    (state_q == StIdle || (state_q == StIssue && ex_ready));
  assign accept   = id_valid && id_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    illegal_d  = 1'b0;
    if (flush) begin
      state_d    = StIdle;
      cnt_d      = '0;
      word_d     = '0;
      ex_valid_d = 1'b0;
      ex_rd_d    = '0;
    end else if (accept) begin
      word_d    = dec_word;
      ex_rd_d   = id_rd;
      illegal_d = dec_illegal;
      if (dec_multi) begin
        state_d    = StHold;
        cnt_d      = dec_cnt;
        ex_valid_d = 1'b0;
      end else begin
        state_d    = StIssue;
        cnt_d      = '0;
        ex_valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        StHold: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_d    = StIssue;
            ex_valid_d = 1'b1;
          end
        end
        StIssue: begin
          if (ex_ready) begin
            state_d    = StIdle;
            word_d     = '0;
            ex_valid_d = 1'b0;
            ex_rd_d    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ALU_Signals = word_q;
  assign ex_rd       = ex_rd_q;
  assign illegal_op  = illegal_q;

endmodule
